// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one iterative divider among NREQ requesters
// Latches the winner's operands, starts the divider, and returns quotient/remainder/error with a done pulse.
module div_arbiter #(
  parameter int NREQ      = 4,
  parameter int GUARD_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   dv_bus,
  input  logic [32*NREQ-1:0]   dr_bus,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          result_out,
  output logic [31:0]          mod_out,
  output logic [1:0]           err_out,
  output logic                 busy,
  output logic                 div_init,
  output logic [31:0]          div_DV,
  output logic [31:0]          div_DR,
  input  logic                 div_ready,
  input  logic [31:0]          div_result,
  input  logic [31:0]          div_mod
);

  localparam int SW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] sel;
  logic [SW-1:0] win;
  logic [SW-1:0] cand;
  logic          found;
  logic [7:0]    gcnt;
  logic [7:0]    tcnt;
  logic [31:0]   dv_arr [NREQ];
  logic [31:0]   dr_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign dv_arr[i] = dv_bus[32*i +: 32];
    assign dr_arr[i] = dr_bus[32*i +: 32];
  end

  // First requester above the last winner, wrapping, so the last winner gets lowest priority.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = SW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= SW'(NREQ - 1);
      sel        <= '0;
      gnt        <= '0;
      done       <= '0;
      result_out <= '0;
      mod_out    <= '0;
      err_out    <= '0;
      busy       <= 1'b0;
      div_init   <= 1'b0;
      div_DV     <= '0;
      div_DR     <= '0;
      gcnt       <= '0;
      tcnt       <= '0;
    end else begin
      div_init <= 1'b0;
      done     <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            sel    <= win;
            gnt    <= ONE << win;
            div_DV <= dv_arr[win];
            div_DR <= dr_arr[win];
            busy   <= 1'b1;
            // Divide-by-zero never reaches the divider.
            if (dr_arr[win] == 32'd0) begin
              state      <= S_DONE;
              done       <= ONE << win;
              result_out <= '1;
              mod_out    <= dv_arr[win];
              err_out    <= 2'b01;
            end else begin
              state    <= S_ISSUE;
              div_init <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          gcnt  <= 8'(GUARD_CYC);
          tcnt  <= '0;
          state <= S_GUARD;
        end
        S_GUARD: begin
          // div_ready may still be high from the previous operation here.
          gcnt <= gcnt - 8'd1;
          if (gcnt <= 8'd1) state <= S_WAIT;
        end
        S_WAIT: begin
          tcnt <= tcnt + 8'd1;
          if (div_ready) begin
            result_out <= div_result;
            mod_out    <= div_mod;
            err_out    <= 2'b00;
            done       <= gnt;
            state      <= S_DONE;
          end else if (tcnt + 8'd1 == 8'(TIMEOUT)) begin
            result_out <= '0;
            mod_out    <= '0;
            err_out    <= 2'b10;
            done       <= gnt;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          gnt   <= '0;
          ptr   <= sel;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter
// Table of single-request vectors plus hand sequences for round-robin, stale ready, timeout and reset.
module tb_div_arbiter;

  localparam int NREQ  = 4;
  localparam int GUARD = 2;
  localparam int TMO   = 16;
  localparam int LAT   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   dv_bus;
  logic [32*NREQ-1:0]   dr_bus;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [31:0]          result_out;
  logic [31:0]          mod_out;
  logic [1:0]           err_out;
  logic                 busy;
  logic                 div_init;
  logic [31:0]          div_DV;
  logic [31:0]          div_DR;
  logic                 div_ready;
  logic [31:0]          div_result;
  logic [31:0]          div_mod;

  div_arbiter #(.NREQ(NREQ), .GUARD_CYC(GUARD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .dv_bus(dv_bus), .dr_bus(dr_bus),
    .gnt(gnt), .done(done), .result_out(result_out), .mod_out(mod_out),
    .err_out(err_out), .busy(busy), .div_init(div_init), .div_DV(div_DV),
    .div_DR(div_DR), .div_ready(div_ready), .div_result(div_result), .div_mod(div_mod)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int init_cnt = 0;
  int start_cyc = 0;
  bit model_en = 1'b0;
  int mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    init_cnt += int'(div_init);
    if (reset) chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
  end

  // Divider model: ready LAT cycles after div_init, held high until the next start.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_en) begin
        if (div_init) begin
          mcnt      = LAT;
          div_ready = 1'b0;
        end else if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            div_ready  = 1'b1;
            div_result = (div_DR != 0) ? div_DV / div_DR : 32'd0;
            div_mod    = (div_DR != 0) ? div_DV % div_DR : 32'd0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] dv, input logic [31:0] dr);
    dv_bus[32*i +: 32] = dv;
    dr_bus[32*i +: 32] = dr;
  endtask

  task automatic wait_done(output logic [NREQ-1:0] dn, output int lat, output bit gok);
    logic [NREQ-1:0] prev;
    prev = '0;
    dn   = '0;
    lat  = -1;
    gok  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done != 0) begin
        dn  = done;
        lat = cyc - start_cyc;
        if (gnt != done) gok = 1'b0;
        break;
      end
      if (gnt == 0 || (prev != 0 && gnt != prev)) gok = 1'b0;
      prev = gnt;
    end
  endtask

  typedef struct {
    int          sel;
    logic [31:0] dv;
    logic [31:0] dr;
    logic [31:0] q;
    logic [31:0] r;
    logic [1:0]  err;
    int          lat;
    int          inits;
  } vec_t;

  vec_t            vecs [6];
  logic [NREQ-1:0] dn;
  int              lat;
  bit              gok;
  int              i0;
  bit              seen;
  int              ord [6];
  logic [31:0]     q_rr [4];

  initial begin
    vecs[0] = '{0, 32'd100,        32'd7, 32'd14,         32'd2,  2'b00, 7, 1};
    vecs[1] = '{1, 32'd5,          32'd0, 32'hFFFFFFFF,   32'd5,  2'b01, 1, 0};
    vecs[2] = '{2, 32'hFFFFFFFF,   32'd1, 32'hFFFFFFFF,   32'd0,  2'b00, 7, 1};
    vecs[3] = '{3, 32'd7,          32'd9, 32'd0,          32'd7,  2'b00, 7, 1};
    vecs[4] = '{0, 32'd0,          32'd0, 32'hFFFFFFFF,   32'd0,  2'b01, 1, 0};
    vecs[5] = '{3, 32'd1000000,    32'd3, 32'd333333,     32'd1,  2'b00, 7, 1};
    ord  = '{0, 1, 2, 3, 0, 1};
    q_rr = '{32'd3, 32'd7, 32'd10, 32'd13};

    reset = 1'b0; req = '0; dv_bus = '0; dr_bus = '0;
    div_ready = 1'b0; div_result = '0; div_mod = '0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init", div_init, 0);
    chk("rst_result", result_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_dv", div_DV, 0);
    tick();
    reset = 1'b1;
    model_en = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      tick();
      set_op(vecs[v].sel, vecs[v].dv, vecs[v].dr);
      req = NREQ'(1) << vecs[v].sel;
      start_cyc = cyc;
      i0 = init_cnt;
      wait_done(dn, lat, gok);
      req = '0;
      chk($sformatf("v%0d_done", v), dn, 64'(1) << vecs[v].sel);
      chk($sformatf("v%0d_result", v), result_out, vecs[v].q);
      chk($sformatf("v%0d_mod", v), mod_out, vecs[v].r);
      chk($sformatf("v%0d_err", v), err_out, vecs[v].err);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_gnt_hold", v), gok, 1);
      chk($sformatf("v%0d_div_dv", v), div_DV, vecs[v].dv);
      chk($sformatf("v%0d_div_dr", v), div_DR, vecs[v].dr);
      chk($sformatf("v%0d_inits", v), init_cnt - i0, vecs[v].inits);
      chk($sformatf("v%0d_busy", v), busy, 1);
    end

    // Round-robin with all four requests held continuously.
    tick();
    for (int i = 0; i < 4; i++) set_op(i, 32'(10 * (i + 1) + 1), 32'd3);
    req = '1;
    start_cyc = cyc;
    for (int j = 0; j < 6; j++) begin
      wait_done(dn, lat, gok);
      chk($sformatf("rr%0d_order", j), dn, 64'(1) << ord[j]);
      chk($sformatf("rr%0d_result", j), result_out, q_rr[ord[j]]);
    end
    req = '0;

    // Stale ready: high through ISSUE/GUARD, low 10 cycles in WAIT, then high.
    model_en = 1'b0;
    div_ready = 1'b1; div_result = 32'hAAAA; div_mod = 32'd1;
    tick();
    set_op(2, 32'd50, 32'd5);
    req = 4'b0100;
    start_cyc = cyc;
    repeat (4) tick();
    div_ready = 1'b0; div_result = '0; div_mod = '0;
    repeat (10) tick();
    div_ready = 1'b1; div_result = 32'd10; div_mod = 32'd0;
    wait_done(dn, lat, gok);
    req = '0;
    chk("stale_done", dn, 4'b0100);
    chk("stale_result", result_out, 10);
    chk("stale_mod", mod_out, 0);
    chk("stale_err", err_out, 0);
    chk("stale_latency", lat, 15);

    // Timeout with div_ready stuck low.
    div_ready = 1'b0;
    tick();
    set_op(1, 32'd9, 32'd2);
    req = 4'b0010;
    start_cyc = cyc;
    wait_done(dn, lat, gok);
    req = '0;
    chk("tmo_done", dn, 4'b0010);
    chk("tmo_result", result_out, 0);
    chk("tmo_mod", mod_out, 0);
    chk("tmo_err", err_out, 2'b10);
    chk("tmo_latency", lat, 20);
    model_en = 1'b1;
    mcnt = 0;
    tick();
    set_op(0, 32'd100, 32'd7);
    req = 4'b0001;
    start_cyc = cyc;
    wait_done(dn, lat, gok);
    req = '0;
    chk("post_tmo_done", dn, 4'b0001);
    chk("post_tmo_result", result_out, 14);
    chk("post_tmo_err", err_out, 0);
    chk("post_tmo_latency", lat, 7);

    // Reset while in WAIT.
    tick();
    set_op(3, 32'd20, 32'd4);
    req = 4'b1000;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk("rstw_busy", busy, 0);
    chk("rstw_gnt", gnt, 0);
    chk("rstw_done", done, 0);
    chk("rstw_init", div_init, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done != 0) seen = 1'b1;
    end
    chk("rstw_no_done", seen, 0);
    tick();
    set_op(0, 32'd30, 32'd4);
    set_op(2, 32'd17, 32'd5);
    req = 4'b0101;
    start_cyc = cyc;
    wait_done(dn, lat, gok);
    req = 4'b0100;
    chk("rstw_first", dn, 4'b0001);
    chk("rstw_first_result", result_out, 7);
    chk("rstw_first_mod", mod_out, 2);
    wait_done(dn, lat, gok);
    req = '0;
    chk("rstw_second", dn, 4'b0100);
    chk("rstw_second_result", result_out, 3);
    chk("rstw_second_mod", mod_out, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
